// File: rtl/pattern_serializer.sv
// pattern_serializer: two-channel parallel-to-serial stage feeding the A/B
// bit-stream inputs of a downstream practice block. Two WIDTH-bit words are
// captured on a load handshake and shifted out LSB-first, one bit per clock,
// framed by valid/last/done.
//
// Optional feature, selected by the SER_REPEAT_EN macro:
//   defined   - a private copy of the captured words is kept, and a load seen
//               on the edge leaving the last bit restarts the same words
//               gap-free from bit 0.
//   undefined - no copy registers; load is ignored outside the idle state.
module pattern_serializer #(
  parameter int   WIDTH      = 9,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             ready,
  output logic             A,
  output logic             B,
  output logic             valid,
  output logic             last,
  output logic             done
);

  // Bit counter wide enough to index WIDTH-1, never narrower than one bit.
  localparam int CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic {
    StIdle  = 1'b0,
    StShift = 1'b1
  } state_t;

  state_t           stateQ;
  logic [WIDTH-1:0] shAQ;
  logic [WIDTH-1:0] shBQ;
  logic [CntW-1:0]  cntQ;
  logic             aQ;
  logic             bQ;
  logic             validQ;
  logic             lastQ;
  logic             doneQ;

`ifdef SER_REPEAT_EN
  logic [WIDTH-1:0] copyAQ;
  logic [WIDTH-1:0] copyBQ;
`endif

  logic             atLastBit;
  logic [CntW-1:0]  cntIncD;
  logic             lastD;

  assign atLastBit = (cntQ == LastCnt);
  assign cntIncD   = cntQ + CntOne;
  assign lastD     = (cntIncD == LastCnt);

  assign ready = (stateQ == StIdle);
  assign A     = aQ;
  assign B     = bQ;
  assign valid = validQ;
  assign last  = lastQ;
  assign done  = doneQ;

  // Serializer FSM: capture on an accepted load, shift one bit per clock,
  // then frame the end of the word with a single done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ <= StIdle;
      shAQ   <= '0;
      shBQ   <= '0;
      cntQ   <= '0;
      aQ     <= IDLE_LEVEL;
      bQ     <= IDLE_LEVEL;
      validQ <= 1'b0;
      lastQ  <= 1'b0;
      doneQ  <= 1'b0;
`ifdef SER_REPEAT_EN
      copyAQ <= '0;
      copyBQ <= '0;
`endif
    end else begin
      case (stateQ)
        StIdle: begin
          doneQ <= 1'b0;
          if (load) begin
            shAQ   <= data_a >> 1;
            shBQ   <= data_b >> 1;
            aQ     <= data_a[0];
            bQ     <= data_b[0];
            validQ <= 1'b1;
            cntQ   <= '0;
            lastQ  <= (WIDTH == 1);
            stateQ <= StShift;
`ifdef SER_REPEAT_EN
            copyAQ <= data_a;
            copyBQ <= data_b;
`endif
          end else begin
            aQ     <= IDLE_LEVEL;
            bQ     <= IDLE_LEVEL;
            validQ <= 1'b0;
            lastQ  <= 1'b0;
          end
        end

        StShift: begin
          if (!atLastBit) begin
            aQ     <= shAQ[0];
            bQ     <= shBQ[0];
            shAQ   <= shAQ >> 1;
            shBQ   <= shBQ >> 1;
            cntQ   <= cntIncD;
            lastQ  <= lastD;
            doneQ  <= 1'b0;
`ifdef SER_REPEAT_EN
          end else if (load) begin
            // Restart from the private copy so the stream continues without a gap.
            aQ     <= copyAQ[0];
            bQ     <= copyBQ[0];
            shAQ   <= copyAQ >> 1;
            shBQ   <= copyBQ >> 1;
            cntQ   <= '0;
            validQ <= 1'b1;
            lastQ  <= (WIDTH == 1);
            doneQ  <= 1'b1;
`endif
          end else begin
            aQ     <= IDLE_LEVEL;
            bQ     <= IDLE_LEVEL;
            validQ <= 1'b0;
            lastQ  <= 1'b0;
            doneQ  <= 1'b1;
            stateQ <= StIdle;
          end
        end

        default: begin
          stateQ <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_serializer.sv
// tb_pattern_serializer: scoreboard bench for pattern_serializer. Stimulus
// pushes the expected serial bits and done pulses; a monitor on the falling
// edge pops and compares whenever the DUT presents a payload bit or a done.
// A second instance with WIDTH=1 covers the single-bit word case.
module tb_pattern_serializer;

  localparam int   TW      = 9;
  localparam logic IdleLvl = 1'b0;

  typedef struct {
    logic a;
    logic b;
    logic lst;
    int   gap;
  } bitExp_t;

  logic          clk;
  logic          reset;
  logic          load;
  logic [TW-1:0] dataA;
  logic [TW-1:0] dataB;
  logic          ready;
  logic          serA;
  logic          serB;
  logic          valid;
  logic          last;
  logic          done;

  logic          load1;
  logic          dataA1;
  logic          dataB1;
  logic          ready1;
  logic          serA1;
  logic          serB1;
  logic          valid1;
  logic          last1;
  logic          done1;

  int            testCount = 0;
  int            failCount = 0;
  int            doneExp   = 0;
  bitExp_t       expQ[$];

  pattern_serializer #(.WIDTH(TW), .IDLE_LEVEL(IdleLvl)) dut (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .data_a (dataA),
    .data_b (dataB),
    .ready  (ready),
    .A      (serA),
    .B      (serB),
    .valid  (valid),
    .last   (last),
    .done   (done)
  );

  pattern_serializer #(.WIDTH(1), .IDLE_LEVEL(IdleLvl)) dutW1 (
    .clk    (clk),
    .reset  (reset),
    .load   (load1),
    .data_a (dataA1),
    .data_b (dataB1),
    .ready  (ready1),
    .A      (serA1),
    .B      (serB1),
    .valid  (valid1),
    .last   (last1),
    .done   (done1)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name);
    testCount++;
    failCount++;
    $display("[TB] FAIL %s: event not expected or did not occur", name);
  endtask

  // Queue one word's bits LSB-first; gapFirst is the required idle run before bit 0 (-1 = don't care).
  task automatic pushWord(input logic [TW-1:0] a, input logic [TW-1:0] b, input int gapFirst);
    bitExp_t e;
    for (int i = 0; i < TW; i++) begin
      e.a   = a[i];
      e.b   = b[i];
      e.lst = (i == TW - 1);
      e.gap = (i == 0) ? gapFirst : 0;
      expQ.push_back(e);
    end
    doneExp++;
  endtask

  task automatic applyStimulus(input logic [TW-1:0] a, input logic [TW-1:0] b, input int gapFirst, input bit keepLoad);
    int waitCycles;
    waitCycles = 0;
    while (!ready && waitCycles < 50) begin
      @(posedge clk);
      #1;
      waitCycles++;
    end
    if (!ready) begin
      reportFail("readyTimeout");
      return;
    end
    dataA = a;
    dataB = b;
    load  = 1'b1;
    pushWord(a, b, gapFirst);
    @(posedge clk);
    #1;
    if (!keepLoad) load = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int waitCycles;
    waitCycles = 0;
    while ((expQ.size() != 0 || doneExp != 0) && waitCycles < 200) begin
      @(posedge clk);
      #1;
      waitCycles++;
    end
    if (expQ.size() != 0 || doneExp != 0) begin
      reportFail(name);
      expQ.delete();
      doneExp = 0;
    end
  endtask

  // Monitor: compares every presented bit against the scoreboard, checks idle levels and done timing.
  initial begin
    bitExp_t e;
    int cycle;
    int idleRun;
    int lastCycle;
    cycle     = 0;
    idleRun   = 0;
    lastCycle = -10;
    forever begin
      @(negedge clk);
      cycle++;
      if (!reset) begin
        idleRun   = 0;
        lastCycle = -10;
        continue;
      end
      if (valid) begin
        if (expQ.size() == 0) begin
          reportFail("unexpectedBit");
        end else begin
          e = expQ.pop_front();
          checkOutput("bitA", {31'd0, serA}, {31'd0, e.a});
          checkOutput("bitB", {31'd0, serB}, {31'd0, e.b});
          checkOutput("bitLast", {31'd0, last}, {31'd0, e.lst});
          if (e.gap >= 0) checkOutput("gapBeforeWord", idleRun, e.gap);
        end
        idleRun = 0;
        if (last) lastCycle = cycle;
      end else begin
        checkOutput("idleLevel", {29'd0, serA, serB, last}, {29'd0, IdleLvl, IdleLvl, 1'b0});
        idleRun++;
      end
      if (done) begin
        if (doneExp == 0) begin
          reportFail("unexpectedDone");
        end else begin
          doneExp--;
          checkOutput("doneTiming", cycle, lastCycle + 1);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence.
  initial begin
    reset  = 1'b0;
    load   = 1'b0;
    dataA  = '0;
    dataB  = '0;
    load1  = 1'b0;
    dataA1 = 1'b0;
    dataB1 = 1'b0;

    // Reset held low for three cycles, then released.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetState", {26'd0, ready, serA, serB, valid, last, done}, {26'd0, 1'b1, 5'b00000});
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("postReset", {26'd0, ready, serA, serB, valid, last, done}, {26'd0, 1'b1, 5'b00000});

    // Single word with a one-cycle load.
    applyStimulus(9'b011101110, 9'b001000100, -1, 1'b0);
    checkOutput("busyReady", {31'd0, ready}, 32'd0);
    waitDrain("drainWord1");

`ifdef SER_REPEAT_EN
    // Load held high: the captured word repeats gap-free from the private copy.
    applyStimulus(9'b011101110, 9'b001000100, -1, 1'b1);
    pushWord(9'b011101110, 9'b001000100, 0);
    pushWord(9'b011101110, 9'b001000100, 0);
    dataA = 9'h0F3;
    dataB = 9'h1C1;
    repeat (20) @(posedge clk);
    #1;
    load = 1'b0;
    waitDrain("drainRepeat");
`else
    // Load held high: second word follows after one idle cycle; mid-word data changes ignored.
    applyStimulus(9'h1FF, 9'h000, -1, 1'b1);
    dataA = 9'h0F3;
    dataB = 9'h1C1;
    repeat (3) @(posedge clk);
    #1;
    dataA = 9'h000;
    dataB = 9'h1FF;
    applyStimulus(9'h155, 9'h0AA, 1, 1'b0);
    dataA = 9'h1E0;
    dataB = 9'h01F;
    waitDrain("drainBackToBack");
`endif

    // Reset asserted while bit 4 is on the line aborts the word without done.
    @(posedge clk);
    #1;
    applyStimulus(9'h1A5, 9'h05A, -1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("abortOutputs", {27'd0, serA, serB, valid, last, done}, 32'd0);
    checkOutput("abortReady", {31'd0, ready}, 32'd1);
    expQ.delete();
    doneExp = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(9'h0C3, 9'h13C, -1, 1'b0);
    waitDrain("drainAfterAbort");

    // Single-bit word on the WIDTH=1 instance.
    dataA1 = 1'b1;
    dataB1 = 1'b1;
    load1  = 1'b1;
    @(posedge clk);
    #1;
    load1 = 1'b0;
    checkOutput("w1Bit", {26'd0, ready1, serA1, serB1, valid1, last1, done1}, {26'd0, 6'b011110});
    @(posedge clk);
    #1;
    checkOutput("w1Done", {26'd0, ready1, serA1, serB1, valid1, last1, done1}, {26'd0, 6'b100001});
    @(posedge clk);
    #1;
    checkOutput("w1Idle", {26'd0, ready1, serA1, serB1, valid1, last1, done1}, {26'd0, 6'b100000});

    checkOutput("scoreboardEmpty", expQ.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
